// File: rtl/audio_serial_port.sv
// WM8731-class codec serial port: m_clk/b_clk/LR generation, I2S or left-justified
// sample serialiser/deserialiser, and first-word-fall-through DAC/ADC sample FIFOs.

module audio_serial_port #(
  parameter int SAMPLE_W = 16,
  parameter int SLOT_W   = 32,
  parameter int BCLK_DIV = 4,
  parameter int MCLK_DIV = 2,
  parameter int FIFO_AW  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  fmt,
  input  logic                  loopback,
  input  logic                  adcdat,
  output logic                  m_clk,
  output logic                  b_clk,
  output logic                  dac_lr_clk,
  output logic                  adc_lr_clk,
  output logic                  dacdat,
  input  logic [2*SAMPLE_W-1:0] dac_fifo_in,
  input  logic                  wr_dac_fifo,
  output logic                  dac_fifo_full,
  output logic [FIFO_AW:0]      dac_level,
  output logic [2*SAMPLE_W-1:0] adc_fifo_out,
  input  logic                  rd_adc_fifo,
  output logic                  adc_fifo_empty,
  output logic [FIFO_AW:0]      adc_level,
  output logic                  dac_underrun,
  output logic                  adc_overrun,
  input  logic                  clr_flags
);

  localparam int WORD_W     = 2 * SAMPLE_W;
  localparam int FIFO_DEPTH = 2 ** FIFO_AW;
  localparam int DIV_W      = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
  localparam int MDIV_W     = (MCLK_DIV > 1) ? $clog2(MCLK_DIV) : 1;
  localparam int SLOT_CW    = $clog2(SLOT_W);
  localparam logic [SAMPLE_W-1:0] MSB_MASK = {1'b1, {(SAMPLE_W-1){1'b0}}};

  typedef enum logic {IDLE, RUN} state_t;

  state_t              state, state_next;
  logic [MDIV_W-1:0]   mclk_cnt;
  logic [DIV_W-1:0]    div_cnt;
  logic [SLOT_CW-1:0]  slot_bit;
  logic [SLOT_CW-1:0]  data_idx;
  logic                lr;
  logic                frame_first, frame_last, bclk_rise;
  logic                fmt_q, loop_q, fmt_eff;
  logic                bit_valid, rx_bit;
  logic                dac_empty, adc_full;
  logic [WORD_W-1:0]   dac_head, tx_word, tx_src;
  logic [SAMPLE_W-1:0] tx_sample, rx_left, rx_right;

  // m_clk runs whenever reset is low, independent of the serialiser state
  always_ff @(posedge clk) begin
    if (reset) begin
      mclk_cnt <= '0;
      m_clk    <= 1'b0;
    end else if (mclk_cnt == MDIV_W'(MCLK_DIV - 1)) begin
      mclk_cnt <= '0;
      m_clk    <= ~m_clk;
    end else begin
      mclk_cnt <= mclk_cnt + 1'b1;
    end
  end

  assign frame_first = (state == RUN) && (div_cnt == '0) && !b_clk &&
                       (slot_bit == '0) && !lr;
  assign frame_last  = (state == RUN) && (div_cnt == DIV_W'(BCLK_DIV - 1)) && b_clk &&
                       (slot_bit == SLOT_CW'(SLOT_W - 1)) && lr;
  assign bclk_rise   = (state == RUN) && (div_cnt == DIV_W'(BCLK_DIV - 1)) && !b_clk;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (enable) state_next = RUN;
      RUN:     if (frame_last && !enable) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // b_clk, slot position and LR all advance together so LR and data move on b_clk falls
  always_ff @(posedge clk) begin
    if (reset || state != RUN) begin
      div_cnt  <= '0;
      b_clk    <= 1'b0;
      slot_bit <= '0;
      lr       <= 1'b0;
    end else if (div_cnt == DIV_W'(BCLK_DIV - 1)) begin
      div_cnt <= '0;
      b_clk   <= ~b_clk;
      if (b_clk) begin
        if (slot_bit == SLOT_CW'(SLOT_W - 1)) begin
          slot_bit <= '0;
          lr       <= ~lr;
        end else begin
          slot_bit <= slot_bit + 1'b1;
        end
      end
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  assign dac_lr_clk = lr;
  assign adc_lr_clk = lr;

  // During the first clk of a frame the popped word and fmt are not yet registered
  assign tx_src    = frame_first ? dac_head : tx_word;
  assign fmt_eff   = frame_first ? fmt : fmt_q;
  assign data_idx  = fmt_eff ? slot_bit : slot_bit - 1'b1;
  assign bit_valid = (state == RUN) && (fmt_eff || slot_bit != '0) &&
                     (data_idx < SLOT_CW'(SAMPLE_W));
  assign tx_sample = lr ? tx_src[SAMPLE_W-1:0] : tx_src[WORD_W-1:SAMPLE_W];
  assign dacdat    = bit_valid && (|(tx_sample & (MSB_MASK >> data_idx)));
  assign rx_bit    = loop_q ? dacdat : adcdat;

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_word  <= '0;
      fmt_q    <= 1'b0;
      loop_q   <= 1'b0;
      rx_left  <= '0;
      rx_right <= '0;
    end else begin
      if (frame_first) begin
        tx_word <= tx_src;
        fmt_q   <= fmt;
        loop_q  <= loopback;
      end
      if (bclk_rise && bit_valid) begin
        if (lr) rx_right <= {rx_right[SAMPLE_W-2:0], rx_bit};
        else    rx_left  <= {rx_left[SAMPLE_W-2:0], rx_bit};
      end
    end
  end

  // Index 0 is the DAC FIFO (fed by the processor), index 1 the ADC FIFO (fed per frame)
  for (genvar f = 0; f < 2; f++) begin : g_fifo
    logic [WORD_W-1:0]  mem [FIFO_DEPTH];
    logic [WORD_W-1:0]  wdata, head;
    logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
    logic [FIFO_AW:0]   level;
    logic               wr, rd, wr_ok, rd_ok, empty, full;

    assign wdata = (f == 0) ? dac_fifo_in : {rx_left, rx_right};
    assign wr    = (f == 0) ? wr_dac_fifo : frame_last;
    assign rd    = (f == 0) ? frame_first : rd_adc_fifo;
    assign empty = (level == '0);
    assign full  = (level == (FIFO_AW+1)'(FIFO_DEPTH));
    assign rd_ok = rd && !empty;
    assign wr_ok = wr && (!full || rd_ok);
    assign head  = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
      if (reset) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        level  <= '0;
      end else begin
        if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
        if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
        if (wr_ok && !rd_ok)      level <= level + 1'b1;
        else if (rd_ok && !wr_ok) level <= level - 1'b1;
      end
    end

    always_ff @(posedge clk) begin
      if (wr_ok) mem[wr_ptr] <= wdata;
    end
  end

  assign dac_head       = g_fifo[0].head;
  assign dac_empty      = g_fifo[0].empty;
  assign dac_fifo_full  = g_fifo[0].full;
  assign dac_level      = g_fifo[0].level;
  assign adc_fifo_out   = g_fifo[1].head;
  assign adc_fifo_empty = g_fifo[1].empty;
  assign adc_full       = g_fifo[1].full;
  assign adc_level      = g_fifo[1].level;

  // A new error event beats a simultaneous clear
  always_ff @(posedge clk) begin
    if (reset) begin
      dac_underrun <= 1'b0;
      adc_overrun  <= 1'b0;
    end else begin
      if (frame_first && dac_empty)                 dac_underrun <= 1'b1;
      else if (clr_flags)                           dac_underrun <= 1'b0;
      if (frame_last && adc_full && !rd_adc_fifo)   adc_overrun  <= 1'b1;
      else if (clr_flags)                           adc_overrun  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_audio_serial_port.sv
// Directed self-checking bench for audio_serial_port with default parameters
// (16-bit samples, 32-bit slots, 512 clk per frame, 16-word FIFOs).

module tb_audio_serial_port;

  logic        clk = 1'b0;
  logic        reset, enable, fmt, loopback, adcdat;
  logic        m_clk, b_clk, dac_lr_clk, adc_lr_clk, dacdat;
  logic [31:0] dac_fifo_in;
  logic        wr_dac_fifo, dac_fifo_full;
  logic [4:0]  dac_level, adc_level;
  logic [31:0] adc_fifo_out;
  logic        rd_adc_fifo, adc_fifo_empty;
  logic        dac_underrun, adc_overrun, clr_flags;

  int          tests_run = 0;
  int          tests_failed = 0;
  int          toggles;
  logic        prev_m, idle_bad, dac_or;
  logic [63:0] cap;
  logic [31:0] words [16];

  audio_serial_port dut (
    .clk(clk), .reset(reset), .enable(enable), .fmt(fmt), .loopback(loopback),
    .adcdat(adcdat), .m_clk(m_clk), .b_clk(b_clk), .dac_lr_clk(dac_lr_clk),
    .adc_lr_clk(adc_lr_clk), .dacdat(dacdat), .dac_fifo_in(dac_fifo_in),
    .wr_dac_fifo(wr_dac_fifo), .dac_fifo_full(dac_fifo_full), .dac_level(dac_level),
    .adc_fifo_out(adc_fifo_out), .rd_adc_fifo(rd_adc_fifo),
    .adc_fifo_empty(adc_fifo_empty), .adc_level(adc_level),
    .dac_underrun(dac_underrun), .adc_overrun(adc_overrun), .clr_flags(clr_flags)
  );

  always #5 clk = ~clk;

  // Advance n rising edges and settle 1 time unit past the last one
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    tests_run++;
    assert (observed === expected) else begin
      tests_failed++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] word);
    dac_fifo_in = word;
    wr_dac_fifo = 1'b1;
    step(1);
    wr_dac_fifo = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b1; enable = 1'b0; fmt = 1'b0; loopback = 1'b0; adcdat = 1'b0;
    dac_fifo_in = '0; wr_dac_fifo = 1'b0; rd_adc_fifo = 1'b0; clr_flags = 1'b0;
    step(3);
    checkOutput("reset_clocks", 64'({m_clk, b_clk, dac_lr_clk, adc_lr_clk, dacdat}), 64'd0);
    checkOutput("reset_levels", 64'({dac_level, adc_level}), 64'd0);
    checkOutput("reset_flags", 64'({dac_underrun, adc_overrun}), 64'd0);
    checkOutput("reset_adc_out", 64'(adc_fifo_out), 64'd0);
    checkOutput("reset_empty_full", 64'({adc_fifo_empty, dac_fifo_full}), 64'b10);
    reset = 1'b0;

    // Idle for 100 clk: serial clocks quiet, m_clk period 4 clk
    prev_m = m_clk; toggles = 0; idle_bad = 1'b0;
    for (int i = 0; i < 100; i++) begin
      step(1);
      if (m_clk !== prev_m) toggles++;
      prev_m = m_clk;
      idle_bad = idle_bad | b_clk | dac_lr_clk | adc_lr_clk | dacdat;
    end
    checkOutput("idle_outputs", 64'(idle_bad), 64'd0);
    checkOutput("mclk_toggles", 64'(toggles), 64'd50);
    checkOutput("idle_levels", 64'({dac_level, adc_level}), 64'd0);

    // Left-justified loopback frame; enable dropped mid-frame
    fmt = 1'b1; loopback = 1'b1;
    applyStimulus(32'h1234ABCD);
    checkOutput("dac_level_write", 64'(dac_level), 64'd1);
    enable = 1'b1;
    step(1);
    step(1);
    enable = 1'b0;
    checkOutput("dac_level_pop", 64'(dac_level), 64'd0);
    step(3);
    checkOutput("bclk_high_c4", 64'({b_clk, dac_lr_clk}), 64'b10);
    step(256);
    checkOutput("lr_right_slot", 64'({b_clk, dac_lr_clk, adc_lr_clk}), 64'b111);
    step(251);
    checkOutput("last_clk_state", 64'({b_clk, dac_lr_clk, adc_level}), 64'({1'b1, 1'b1, 5'd0}));
    step(1);
    checkOutput("frame_end_idle", 64'({b_clk, dac_lr_clk}), 64'd0);
    checkOutput("lj_loop_level", 64'(adc_level), 64'd1);
    checkOutput("lj_loop_word", 64'(adc_fifo_out), 64'h1234ABCD);
    checkOutput("lj_no_underrun", 64'({dac_underrun, adc_fifo_empty}), 64'd0);
    step(5);
    checkOutput("stays_idle", 64'(b_clk), 64'd0);
    rd_adc_fifo = 1'b1;
    step(1);
    rd_adc_fifo = 1'b0;
    checkOutput("adc_pop_empty", 64'({adc_fifo_empty, adc_fifo_out}), 64'({1'b1, 32'd0}));

    // I2S frame: capture dacdat mid b_clk-high of every bit, adcdat held high
    fmt = 1'b0; loopback = 1'b0; adcdat = 1'b1;
    applyStimulus(32'h8001FFFF);
    enable = 1'b1;
    step(1);
    enable = 1'b0;
    step(5);
    cap = '0;
    for (int b = 0; b < 64; b++) begin
      cap[b] = dacdat;
      if (b < 63) step(8);
    end
    checkOutput("i2s_frame_bits", cap, 64'h0001_FFFE_0001_0002);
    checkOutput("i2s_slot0_zero", 64'(cap[0]), 64'd0);
    checkOutput("i2s_msb_slot1", 64'(cap[1]), 64'd1);
    checkOutput("i2s_lsb_slot16", 64'(cap[16]), 64'd1);
    checkOutput("i2s_tail_zero", 64'(cap[31:17]), 64'd0);
    step(3);
    checkOutput("i2s_adc_word", 64'(adc_fifo_out), 64'hFFFFFFFF);
    adcdat = 1'b0;
    rd_adc_fifo = 1'b1;
    step(1);
    rd_adc_fifo = 1'b0;

    // Two underrun frames with clears: plain clear, then clear colliding with an event
    fmt = 1'b1;
    enable = 1'b1;
    step(1);
    checkOutput("underrun_not_yet", 64'(dac_underrun), 64'd0);
    step(1);
    checkOutput("underrun_set", 64'(dac_underrun), 64'd1);
    dac_or = dacdat;
    for (int i = 2; i < 1024; i++) begin
      step(1);
      if (i == 301) begin
        clr_flags = 1'b0;
        checkOutput("clr_clears", 64'(dac_underrun), 64'd0);
      end
      if (i == 513) begin
        clr_flags = 1'b0;
        checkOutput("set_beats_clr", 64'(dac_underrun), 64'd1);
      end
      dac_or = dac_or | dacdat;
      if (i == 300 || i == 512) clr_flags = 1'b1;
      if (i == 600) enable = 1'b0;
    end
    step(1);
    checkOutput("underrun_dacdat_zero", 64'(dac_or), 64'd0);
    checkOutput("underrun_adc_level", 64'({dac_underrun, adc_level}), 64'({1'b1, 5'd2}));
    clr_flags = 1'b1;
    step(1);
    clr_flags = 1'b0;
    checkOutput("underrun_cleared", 64'(dac_underrun), 64'd0);
    rd_adc_fifo = 1'b1;
    step(2);
    rd_adc_fifo = 1'b0;
    checkOutput("adc_drained", 64'(adc_fifo_empty), 64'd1);
    loopback = 1'b1;
    applyStimulus(32'hA5A55A5A);
    enable = 1'b1;
    step(1);
    enable = 1'b0;
    step(512);
    checkOutput("recover_word", 64'(adc_fifo_out), 64'hA5A55A5A);
    checkOutput("recover_no_underrun", 64'(dac_underrun), 64'd0);

    // Overrun: 16 words plus one rejected write, 17 loopback frames, no reads
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    for (int i = 0; i < 16; i++) begin
      words[i] = {16'hA000 + 16'(i), 16'h5000 + 16'(i)};
      applyStimulus(words[i]);
    end
    checkOutput("dac_full", 64'({dac_fifo_full, dac_level}), 64'({1'b1, 5'd16}));
    applyStimulus(32'hDEADBEEF);
    checkOutput("dac_write_when_full", 64'(dac_level), 64'd16);
    enable = 1'b1;
    step(1);
    step(8200);
    enable = 1'b0;
    step(503);
    checkOutput("overrun_not_yet", 64'({adc_overrun, adc_level}), 64'({1'b0, 5'd16}));
    step(1);
    checkOutput("overrun_set", 64'({adc_overrun, adc_level}), 64'({1'b1, 5'd16}));
    checkOutput("overrun_underrun", 64'({dac_underrun, b_clk}), 64'b10);
    rd_adc_fifo = 1'b1;
    for (int i = 0; i < 16; i++) begin
      checkOutput($sformatf("overrun_word%0d", i), 64'(adc_fifo_out), 64'(words[i]));
      step(1);
    end
    rd_adc_fifo = 1'b0;
    checkOutput("overrun_drained", 64'({adc_fifo_empty, adc_level}), 64'({1'b1, 5'd0}));

    // Reset in the middle of a running frame
    applyStimulus(32'h11112222);
    applyStimulus(32'h33334444);
    enable = 1'b1;
    step(1);
    step(199);
    checkOutput("pre_reset_state", 64'({b_clk, dac_level, dac_underrun}), 64'({1'b1, 5'd1, 1'b1}));
    reset = 1'b1;
    step(1);
    checkOutput("midreset_clocks", 64'({b_clk, dac_lr_clk, adc_lr_clk, dacdat}), 64'd0);
    checkOutput("midreset_levels", 64'({dac_level, adc_level}), 64'd0);
    checkOutput("midreset_flags", 64'({dac_underrun, adc_overrun}), 64'd0);
    reset = 1'b0;
    enable = 1'b0;
    step(10);
    checkOutput("post_reset_idle", 64'(b_clk), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/audio_serial_port.md
Name: audio_serial_port

Overview:
- Parametrised successor to the fixed 16/32-bit codec data path.
- Generates m_clk, b_clk and the LR clocks for a WM8731-class codec.
- Serialises stereo DAC samples and deserialises ADC samples in I2S or left-justified format.
- Contains its own DAC and ADC FIFOs with level outputs, sticky underrun/overrun flags, internal loopback and a frame-aligned enable.
- Sits between the processor-side FIFO interface and the codec pins, alongside the I2C configuration block.

Parameters:
- SAMPLE_W, 16, bits per channel sample; range 8..32.
- SLOT_W, 32, b_clk cycles per channel slot; must be >= SAMPLE_W+1.
- BCLK_DIV, 4, clk cycles per b_clk half-period; must be >= 2.
- MCLK_DIV, 2, clk cycles per m_clk half-period; must be >= 1.
- FIFO_AW, 4, FIFO address width; depth = 2**FIFO_AW words.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- enable  in  1  run serial port; takes effect at frame boundaries
- fmt  in  1  0 = I2S (MSB one b_clk after LR edge), 1 = left-justified (MSB at LR edge)
- loopback  in  1  1 = ADC deserialiser takes internal dacdat instead of adcdat
- adcdat  in  1  codec ADC serial data
- m_clk, b_clk, dac_lr_clk, adc_lr_clk  out  1 each  codec clocks; both LR clocks are identical
- dacdat  out  1  codec DAC serial data
- dac_fifo_in  in  2*SAMPLE_W  write word {left, right}
- wr_dac_fifo  in  1  push strobe
- dac_fifo_full  out  1  DAC FIFO full
- dac_level  out  FIFO_AW+1  DAC FIFO occupancy
- adc_fifo_out  out  2*SAMPLE_W  head word {left, right}; first-word-fall-through
- rd_adc_fifo  in  1  pop strobe
- adc_fifo_empty  out  1  ADC FIFO empty
- adc_level  out  FIFO_AW+1  ADC FIFO occupancy
- dac_underrun, adc_overrun  out  1 each  sticky error flags
- clr_flags  in  1  clears both sticky flags

Behaviour:
- Reset:
  - All clock outputs, dacdat, flags and levels are 0.
  - Both FIFOs are empty; adc_fifo_out = 0.
  - Serialiser is in IDLE.
- m_clk: free-running, toggles every MCLK_DIV clk cycles, including while idle. Only reset stops it.
- State machine IDLE -> RUN:
  - In IDLE: b_clk=0, LR=0, dacdat=0, bit counter=0.
  - The IDLE->RUN transition occurs on the first clk cycle with enable=1.
  - RUN->IDLE occurs only on the last clk cycle of a frame in which enable=0 was sampled at that cycle. A partial frame is never emitted.
- b_clk in RUN: period 2*BCLK_DIV clk; starts low.
- Frame: 2*SLOT_W b_clk cycles. LR=0 for the left slot, LR=1 for the right slot. LR changes on b_clk falling edges.
- DAC path:
  - On the first clk of each frame, pop one DAC FIFO word.
  - If the FIFO is empty: the frame transmits all zeros and dac_underrun is set.
  - dacdat is MSB-first and changes on b_clk falling edges. Bits after SAMPLE_W within a slot are 0.
  - fmt=1: slot bit 0 carries the MSB. fmt=0: slot bit 1 carries the MSB.
- ADC path:
  - adcdat, or dacdat when loopback=1, is sampled on b_clk rising edges using the same bit positions as the DAC path.
  - On the last clk of each frame, push {left, right}.
  - If the ADC FIFO is full: the word is dropped, FIFO contents are unchanged, and adc_overrun is set.
- fmt and loopback are sampled at frame start only. A mid-frame change has no effect until the next frame.
- FIFOs:
  - Write when full is ignored. Read when empty is ignored.
  - Simultaneous read and write when full: both occur; level is unchanged.
  - Simultaneous read and write when empty: only the write occurs.
  - Pointers wrap modulo depth.
  - Levels update one clk after the operation.
  - adc_fifo_out is valid whenever adc_fifo_empty=0 and is 0 when empty.
- Flags:
  - Each flag goes high the clk after its error event.
  - clr_flags clears both flags. If clr_flags and an error event occur in the same cycle, the flag is set (set wins).
- Reset mid-frame: immediate return to IDLE, FIFOs flushed, flags cleared.

Test Plan:
- Reset then idle, enable=0 for 100 clk -> b_clk=0, LR=0, dacdat=0, m_clk period 4 clk, levels 0.
- Defaults, fmt=1, loopback=1: write 0x1234ABCD, enable=1 -> first frame spans 512 clk; adc_fifo_out=0x1234ABCD on the clk after the frame ends; dac_underrun=0.
- Defaults, fmt=0: write 0x8001FFFF -> dacdat=0 in slot bit 0, 1 at slot bit 1 (MSB), 1 at slot bit 16 (LSB of left), 0 for slot bits 17..31; right slot carries 0xFFFF.
- Enable with DAC FIFO empty for 2 frames -> dacdat stays 0, dac_underrun=1; clr_flags then write word -> flag clears, next frame carries the word.
- Loopback, 17 frames, no reads -> adc_level=16, adc_fifo_full reached, adc_overrun=1, first 16 words intact.
- Deassert enable mid-frame -> frame completes the full 512 clk, then IDLE; reset asserted mid-frame -> IDLE and levels 0 on the next clk.
